// File: rtl/print_arbiter_pkg.sv
// rtl/print_arbiter_pkg.sv - shared types and constants for the print arbiter
package print_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W_DEF    = 2;

    localparam logic [1:0] PRINTER_IDLE = 2'd0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/print_arbiter_if.sv
// rtl/print_arbiter_if.sv - requester and printer signal bundle for the print arbiter
interface print_arbiter_if
    import print_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int GIDX_W  = 2
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*ID_W-1:0] req_str_id;
    logic [NUM_REQ-1:0]      req_pending;
    logic [NUM_REQ-1:0]      req_done;
    logic [NUM_REQ-1:0]      req_drop;
    logic [1:0]              printer_state;
    logic                    printer_done;
    logic [ID_W-1:0]         str_id;
    logic                    printer_enable;
    logic                    busy;
    logic [GIDX_W-1:0]       grant_idx;

    modport master (
        input  req_valid, req_str_id, printer_state, printer_done,
        output req_pending, req_done, req_drop, str_id, printer_enable, busy, grant_idx
    );

    modport slave (
        output req_valid, req_str_id, printer_state, printer_done,
        input  req_pending, req_done, req_drop, str_id, printer_enable, busy, grant_idx
    );

endinterface

// File: rtl/print_arbiter_rr_pick.sv
// rtl/print_arbiter_rr_pick.sv - round-robin scan: first pending bit after last_grant, wrapping
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int GIDX_W  = 2
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [GIDX_W-1:0]  last_grant,
    output logic               found,
    output logic [GIDX_W-1:0]  grant
);

    always_comb begin
        int               idx;
        logic [GIDX_W-1:0] sel;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            sel = GIDX_W'(idx);
            if (!found && pending[sel]) begin
                found = 1'b1;
                grant = sel;
            end
        end
    end

endmodule

// File: rtl/print_arbiter.sv
// rtl/print_arbiter.sv - round-robin sharing of the string printer among NUM_REQ requesters
module print_arbiter
    import print_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int GIDX_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    print_arbiter_if.master bus
);

    arb_state_t state, state_n;

    logic [NUM_REQ-1:0] pending_q, pending_n;
    logic [NUM_REQ-1:0] done_q, drop_q, drop_n, clr_vec;
    logic [ID_W-1:0]    id_q [NUM_REQ];
    logic [ID_W-1:0]    str_id_q, str_id_n;
    logic               enable_q, enable_n, busy_q, complete;
    logic [GIDX_W-1:0]  grant_q, grant_n, last_grant;
    logic               pick_found;
    logic [GIDX_W-1:0]  pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GIDX_W  (GIDX_W)
    ) u_pick (
        .pending    (pending_q),
        .last_grant (last_grant),
        .found      (pick_found),
        .grant      (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // The cycle carrying req_done is skipped so the printer has a full cycle to settle back to idle.
    always_comb begin
        state_n  = state;
        grant_n  = grant_q;
        str_id_n = str_id_q;
        enable_n = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found && bus.printer_state == PRINTER_IDLE && done_q == '0) begin
                    grant_n  = pick_idx;
                    str_id_n = id_q[pick_idx];
                    enable_n = 1'b1;
                    state_n  = WAIT_START;
                end
            end
            WAIT_START: begin
                if (bus.printer_state != PRINTER_IDLE) state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.printer_done) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        clr_vec = '0;
        if (complete) clr_vec[grant_q] = 1'b1;
    end

    // A re-request landing in the requester's own done cycle replaces the finished one.
    always_comb begin
        pending_n = pending_q;
        drop_n    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (!pending_q[i] || clr_vec[i]) pending_n[i] = 1'b1;
                else                             drop_n[i]    = 1'b1;
            end else if (clr_vec[i]) begin
                pending_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            done_q     <= '0;
            drop_q     <= '0;
            str_id_q   <= '0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            last_grant <= GIDX_W'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) id_q[i] <= '0;
        end else begin
            pending_q <= pending_n;
            done_q    <= clr_vec;
            drop_q    <= drop_n;
            str_id_q  <= str_id_n;
            enable_q  <= enable_n;
            busy_q    <= (state_n != IDLE);
            grant_q   <= grant_n;
            if (complete) last_grant <= grant_q;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && (!pending_q[i] || clr_vec[i]))
                    id_q[i] <= bus.req_str_id[i*ID_W +: ID_W];
            end
        end
    end

    assign bus.req_pending    = pending_q;
    assign bus.req_done       = done_q;
    assign bus.req_drop       = drop_q;
    assign bus.str_id         = str_id_q;
    assign bus.printer_enable = enable_q;
    assign bus.busy           = busy_q;
    assign bus.grant_idx      = grant_q;

endmodule

// File: tb/tb_print_arbiter.sv
// tb/tb_print_arbiter.sv - directed and randomized checks of print_arbiter against a queue-level model
module tb_print_arbiter;
    import print_arb_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    print_arbiter_if #(.NUM_REQ(N), .ID_W(IW), .GIDX_W(GW)) bus();

    print_arbiter #(.NUM_REQ(N), .ID_W(IW), .GIDX_W(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference model: pending set, stored IDs, last served requester.
    bit              m_pend [N];
    logic [IW-1:0]   m_id   [N];
    int              m_last;

    function automatic int m_pick();
        for (int k = 1; k <= N; k++) begin
            int j = (m_last + k) % N;
            if (m_pend[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_id[i]   = '0;
        end
        m_last = N - 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [N-1:0] v, input logic [N*IW-1:0] ids);
        logic [N-1:0] exp_drop = '0;
        @(negedge clk);
        bus.req_valid  = v;
        bus.req_str_id = ids;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (m_pend[i]) exp_drop[i] = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_id[i]   = ids[i*IW +: IW];
                end
            end
        end
        @(negedge clk);
        bus.req_valid = '0;
        chk("req_drop", bus.req_drop, exp_drop);
        chk("req_pending", bus.req_pending, m_vec());
    endtask

    task automatic serve_one(input logic [N-1:0] mid_v, input logic [N*IW-1:0] mid_ids,
                             input logic [N-1:0] done_v, input logic [N*IW-1:0] done_ids,
                             output int g_obs);
        int k = 0;
        int g;
        logic [N-1:0] exp_drop = '0;
        while (!bus.printer_enable && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!bus.printer_enable) begin
            chk("enable_timeout", bus.printer_enable, 1);
            g_obs = -1;
            return;
        end
        g = m_pick();
        if (g < 0) begin
            chk("spurious_enable", bus.printer_enable, 0);
            g = 0;
        end
        chk("grant_idx", bus.grant_idx, g);
        chk("str_id", bus.str_id, m_id[g]);
        chk("busy_job", bus.busy, 1);
        g_obs = int'(bus.grant_idx);
        bus.printer_state = 2'd1;
        @(negedge clk);
        chk("enable_width", bus.printer_enable, 0);
        if (mid_v != '0) do_req(mid_v, mid_ids);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        bus.printer_done = 1'b1;
        bus.req_valid    = done_v;
        bus.req_str_id   = done_ids;
        m_pend[g] = 1'b0;
        m_last    = g;
        for (int i = 0; i < N; i++) begin
            if (done_v[i]) begin
                if (m_pend[i]) exp_drop[i] = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_id[i]   = done_ids[i*IW +: IW];
                end
            end
        end
        @(negedge clk);
        bus.printer_done  = 1'b0;
        bus.printer_state = 2'd0;
        bus.req_valid     = '0;
        chk("req_done", bus.req_done, 32'd1 << g);
        chk("req_drop_done", bus.req_drop, exp_drop);
        chk("pending_after_done", bus.req_pending, m_vec());
        chk("busy_after_done", bus.busy, 0);
        @(negedge clk);
        chk("req_done_pulse", bus.req_done, 0);
        chk("enable_gap", bus.printer_enable, 0);
    endtask

    initial begin
        int g;
        int k;
        logic [N-1:0]    rv, mv, dv;
        logic [N*IW-1:0] ri, mi, di;

        rst               = 1'b1;
        bus.req_valid     = '0;
        bus.req_str_id    = '0;
        bus.printer_state = 2'd0;
        bus.printer_done  = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_pending", bus.req_pending, 0);
        chk("rst_done", bus.req_done, 0);
        chk("rst_drop", bus.req_drop, 0);
        chk("rst_str_id", bus.str_id, 0);
        chk("rst_enable", bus.printer_enable, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant_idx, 0);
        rst = 1'b0;

        // All four at once, IDs 0..3: served 0,1,2,3
        do_req(4'b1111, 8'hE4);
        for (int i = 0; i < N; i++) begin
            serve_one('0, '0, '0, '0, g);
            chk("rr_order", g, i);
        end

        // Single request: enable two cycles after the pulse with str_id=3
        do_req(4'b0100, 8'h30);
        @(negedge clk);
        chk("single_enable_t2", bus.printer_enable, 1);
        chk("single_str_id", bus.str_id, 3);
        serve_one('0, '0, '0, '0, g);
        chk("single_grant", g, 2);

        // last_grant=2 with 0 and 3 pending: 3 wins, then 0
        do_req(4'b1001, 8'h81);
        serve_one('0, '0, '0, '0, g);
        chk("wrap_first", g, 3);
        serve_one('0, '0, '0, '0, g);
        chk("wrap_second", g, 0);

        // Duplicate mid-job drops; re-request in the done cycle is accepted
        do_req(4'b0010, 8'h08);
        serve_one(4'b0010, 8'h00, 4'b0010, 8'h04, g);
        chk("dup_grant", g, 1);
        serve_one('0, '0, '0, '0, g);
        chk("rereq_grant", g, 1);

        // Printer busy: no enable until printer_state returns to 0
        bus.printer_state = 2'd2;
        do_req(4'b0001, 8'h03);
        repeat (6) begin
            @(negedge clk);
            chk("busy_printer_no_enable", bus.printer_enable, 0);
        end
        bus.printer_state = 2'd0;
        serve_one('0, '0, '0, '0, g);
        chk("busy_printer_grant", g, 0);

        // Reset while waiting for printer_done
        do_req(4'b0101, 8'h31);
        k = 0;
        while (!bus.printer_enable && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("rstjob_enable", bus.printer_enable, 1);
        bus.printer_state = 2'd1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        chk("rstjob_pending", bus.req_pending, 0);
        chk("rstjob_busy", bus.busy, 0);
        chk("rstjob_str_id", bus.str_id, 0);
        chk("rstjob_grant", bus.grant_idx, 0);
        chk("rstjob_enable_low", bus.printer_enable, 0);
        @(negedge clk);
        bus.printer_done = 1'b1;
        @(negedge clk);
        bus.printer_done = 1'b0;
        chk("stray_done", bus.req_done, 0);
        chk("stray_drop", bus.req_drop, 0);
        do_req(4'b0010, 8'h04);
        repeat (4) begin
            @(negedge clk);
            chk("rstjob_hold", bus.printer_enable, 0);
        end
        bus.printer_state = 2'd0;
        serve_one('0, '0, '0, '0, g);
        chk("rstjob_next_grant", g, 1);

        // Randomized traffic
        for (int it = 0; it < 20; it++) begin
            if (m_pick() < 0) begin
                rv = N'($urandom_range(1, (1 << N) - 1));
                ri = N*IW'($urandom);
                do_req(rv, ri);
            end
            mv = ($urandom_range(0, 1) != 0) ? N'($urandom) : '0;
            mi = N*IW'($urandom);
            dv = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            di = N*IW'($urandom);
            serve_one(mv, mi, dv, di, g);
        end
        k = 0;
        while (m_pick() >= 0 && k < 8) begin
            serve_one('0, '0, '0, '0, g);
            k++;
        end
        chk("drain_pending", bus.req_pending, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
